video_signal_generator: RTL and testbench



---
 rtl/video_signal_generator.sv | 102 ++++++++++
 tb/tb_video_signal_generator.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/video_signal_generator.sv
// Video timing generator: pixel/line counters with sync, data-enable and
// new-frame decodes. All decodes are combinational from the counter
// registers, so every output describes the same pixel in the same cycle.
// Optional feature: define VSG_FRAME_COUNTER_EN to build the frame counter
// on o_fc; without it o_fc is tied to zero and no register is built.
module video_signal_generator #(
    parameter int ACTIVE_H_PIXELS = 1280,
    parameter int H_FRONT_PORCH   = 110,
    parameter int H_SYNCH_WIDTH   = 40,
    parameter int H_BACK_PORCH    = 220,
    parameter int ACTIVE_LINES    = 720,
    parameter int V_FRONT_PORCH   = 5,
    parameter int V_SYNCH_WIDTH   = 5,
    parameter int V_BACK_PORCH    = 20,
    parameter int FPS             = 60,
    localparam int H_TOTAL = ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNCH_WIDTH + H_BACK_PORCH,
    localparam int V_TOTAL = ACTIVE_LINES + V_FRONT_PORCH + V_SYNCH_WIDTH + V_BACK_PORCH,
    localparam int SX_W    = $clog2(H_TOTAL),
    localparam int SY_W    = $clog2(V_TOTAL),
    localparam int FC_W    = $clog2(FPS)
) (
    input  logic            i_clk_pxl,
    input  logic            i_reset,
    output logic [SX_W-1:0] o_sx,
    output logic [SY_W-1:0] o_sy,
    output logic            o_hsync,
    output logic            o_vsync,
    output logic            o_de,
    output logic            o_nf,
    output logic [FC_W-1:0] o_fc
);

    // Last counter values before wrap.
    localparam logic [SX_W-1:0] H_LAST = SX_W'(H_TOTAL - 1);
    localparam logic [SY_W-1:0] V_LAST = SY_W'(V_TOTAL - 1);

    // Region boundaries are one bit wider than the counters: an end bound can
    // equal H_TOTAL/V_TOTAL, which may not fit in the counter width.
    localparam logic [SX_W:0] H_ACTIVE_END = (SX_W+1)'(ACTIVE_H_PIXELS);
    localparam logic [SX_W:0] H_SYNC_BEGIN = (SX_W+1)'(ACTIVE_H_PIXELS + H_FRONT_PORCH);
    localparam logic [SX_W:0] H_SYNC_END   = (SX_W+1)'(ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNCH_WIDTH);
    localparam logic [SY_W:0] V_ACTIVE_END = (SY_W+1)'(ACTIVE_LINES);
    localparam logic [SY_W:0] V_SYNC_BEGIN = (SY_W+1)'(ACTIVE_LINES + V_FRONT_PORCH);
    localparam logic [SY_W:0] V_SYNC_END   = (SY_W+1)'(ACTIVE_LINES + V_FRONT_PORCH + V_SYNCH_WIDTH);

    logic [SX_W:0] sx_ext;
    logic [SY_W:0] sy_ext;
    logic          frame_wrap;

    assign sx_ext     = {1'b0, o_sx};
    assign sy_ext     = {1'b0, o_sy};
    assign frame_wrap = (o_sx == H_LAST) && (o_sy == V_LAST);

    // Raster position: pixel counter every clock, line counter on pixel wrap.
    always_ff @(posedge i_clk_pxl or posedge i_reset) begin
        if (i_reset) begin
            o_sx <= '0;
            o_sy <= '0;
        end else if (o_sx == H_LAST) begin
            o_sx <= '0;
            if (o_sy == V_LAST) begin
                o_sy <= '0;
            end else begin
                o_sy <= o_sy + SY_W'(1);
            end
        end else begin
            o_sx <= o_sx + SX_W'(1);
        end
    end

    assign o_hsync = (sx_ext >= H_SYNC_BEGIN) && (sx_ext < H_SYNC_END);
    assign o_vsync = (sy_ext >= V_SYNC_BEGIN) && (sy_ext < V_SYNC_END);
    assign o_de    = (sx_ext < H_ACTIVE_END) && (sy_ext < V_ACTIVE_END);
    assign o_nf    = (o_sx == '0) && (o_sy == '0);

`ifdef VSG_FRAME_COUNTER_EN
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FPS - 1);

    logic [FC_W-1:0] fc;

    // Frame counter advances on the edge that returns the raster to (0,0).
    always_ff @(posedge i_clk_pxl or posedge i_reset) begin
        if (i_reset) begin
            fc <= '0;
        end else if (frame_wrap) begin
            if (fc == FC_LAST) begin
                fc <= '0;
            end else begin
                fc <= fc + FC_W'(1);
            end
        end
    end

    assign o_fc = fc;
`else
    logic unused_frame_wrap;

    assign unused_frame_wrap = frame_wrap;
    assign o_fc              = '0;
`endif

endmodule

// File: tb/tb_video_signal_generator.sv
// Scoreboard bench for video_signal_generator with a reduced raster so that
// several frame-counter periods fit in a short run. The reference model
// derives every output from the number of clock edges since reset release.
module tb_video_signal_generator;

    localparam int HA  = 16;
    localparam int HF  = 3;
    localparam int HS  = 4;
    localparam int HB  = 5;
    localparam int VA  = 10;
    localparam int VF  = 2;
    localparam int VS  = 3;
    localparam int VB  = 4;
    localparam int FPS = 4;
    localparam int H_TOT = HA + HF + HS + HB;
    localparam int V_TOT = VA + VF + VS + VB;
    localparam int SX_W  = $clog2(H_TOT);
    localparam int SY_W  = $clog2(V_TOT);
    localparam int FC_W  = $clog2(FPS);
    localparam int N_CYC = 14000;

    typedef struct {
        int sx;
        int sy;
        int fc;
        int hs;
        int vs;
        int de;
        int nf;
    } exp_t;

    logic            clk = 1'b0;
    logic            i_reset;
    logic [SX_W-1:0] o_sx;
    logic [SY_W-1:0] o_sy;
    logic            o_hsync;
    logic            o_vsync;
    logic            o_de;
    logic            o_nf;
    logic [FC_W-1:0] o_fc;

    exp_t q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    bit   active     = 1'b0;
    int   mon_cyc    = 0;

    video_signal_generator #(
        .ACTIVE_H_PIXELS(HA),
        .H_FRONT_PORCH  (HF),
        .H_SYNCH_WIDTH  (HS),
        .H_BACK_PORCH   (HB),
        .ACTIVE_LINES   (VA),
        .V_FRONT_PORCH  (VF),
        .V_SYNCH_WIDTH  (VS),
        .V_BACK_PORCH   (VB),
        .FPS            (FPS)
    ) dut (
        .i_clk_pxl(clk),
        .i_reset  (i_reset),
        .o_sx     (o_sx),
        .o_sy     (o_sy),
        .o_hsync  (o_hsync),
        .o_vsync  (o_vsync),
        .o_de     (o_de),
        .o_nf     (o_nf),
        .o_fc     (o_fc)
    );

    always #5 clk = ~clk;

    // Expected outputs t clock edges after reset release (t = 0 in reset).
    function automatic exp_t model(int t);
        exp_t e;
        int   frame;
        e.sx  = t % H_TOT;
        e.sy  = (t / H_TOT) % V_TOT;
        frame = t / (H_TOT * V_TOT);
`ifdef VSG_FRAME_COUNTER_EN
        e.fc  = frame % FPS;
`else
        e.fc  = 0 * frame;
`endif
        e.hs  = (e.sx >= HA + HF && e.sx < HA + HF + HS) ? 1 : 0;
        e.vs  = (e.sy >= VA + VF && e.sy < VA + VF + VS) ? 1 : 0;
        e.de  = (e.sx < HA && e.sy < VA) ? 1 : 0;
        e.nf  = (e.sx == 0 && e.sy == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int want);
        vectors++;
        if (act != want) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, mon_cyc, act, want);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (active) begin
                if (q.size() == 0) begin
                    check("queue_empty", 0, 1);
                end else begin
                    e = q.pop_front();
                    check("sx",    int'(o_sx),    e.sx);
                    check("sy",    int'(o_sy),    e.sy);
                    check("fc",    int'(o_fc),    e.fc);
                    check("hsync", int'(o_hsync), e.hs);
                    check("vsync", int'(o_vsync), e.vs);
                    check("de",    int'(o_de),    e.de);
                    check("nf",    int'(o_nf),    e.nf);
                end
                mon_cyc++;
            end
        end
    end

    // Stimulus: reset held at start, one forced mid-line reset, then random
    // short resets. Reset changes 1 ns after a rising edge, so an assertion
    // is observed by the monitor before the next rising edge.
    initial begin
        int t;
        bit rst_prev;
        int hold;
        i_reset  = 1'b1;
        rst_prev = 1'b1;
        t        = 0;
        hold     = 0;
        active   = 1'b1;
        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(posedge clk);
            #1;
            if (rst_prev) t = 0;
            else          t = t + 1;
            if (cyc < 4) begin
                i_reset = 1'b1;
            end else if (cyc == 4) begin
                i_reset = 1'b0;
            end else if (cyc == 6000) begin
                i_reset = 1'b1;
                hold    = 2;
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) i_reset = 1'b0;
            end else if (cyc > 6002 && $urandom_range(0, 799) == 0) begin
                i_reset = 1'b1;
                hold    = int'($urandom_range(1, 3));
            end
            if (i_reset) t = 0;
            q.push_back(model(t));
            rst_prev = i_reset;
        end
        @(posedge clk);
        #1;
        active = 1'b0;
        check("drain", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
